// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set controller: state encoding, field
// indices, BCD field maxima and the field-select one-hot helper.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [1:0] SEL_SS = 2'd0;
    localparam logic [1:0] SEL_MM = 2'd1;
    localparam logic [1:0] SEL_HH = 2'd2;

    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HH = 8'h23;

    localparam int unsigned TIMEOUT_W = 11;

    // One blank bit per field, {hh, mm, ss}; an out-of-range select blanks nothing.
    function automatic logic [2:0] field_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            SEL_SS:  oh = 3'b001;
            SEL_MM:  oh = 3'b010;
            SEL_HH:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational single-step of a two-digit BCD field with wrap at a maximum.
// Increment at/above max wraps to 00; decrement from 00 or from any value
// above max lands on max.
module bcd_field_step (
    input  logic [7:0] value_i,
    input  logic [7:0] max_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] value_o
);

    // Step the BCD value; increment takes precedence if both are asserted.
    always_comb begin
        value_o = value_i;
        if (inc_i) begin
            if (value_i >= max_i) begin
                value_o = 8'h00;
            end else if (value_i[3:0] >= 4'd9) begin
                value_o = {value_i[7:4] + 4'd1, 4'd0};
            end else begin
                value_o = {value_i[7:4], value_i[3:0] + 4'd1};
            end
        end else if (dec_i) begin
            if ((value_i == 8'h00) || (value_i > max_i)) begin
                value_o = max_i;
            end else if (value_i[3:0] == 4'd0) begin
                value_o = {value_i[7:4] - 4'd1, 4'd9};
            end else begin
                value_o = {value_i[7:4], value_i[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: tracks live time in RUN, edits a BCD HH:MM:SS buffer
// in EDIT, and strobes o_load for one cycle in COMMIT. Drives per-field blink
// blanking for the display mux.
// Optional feature macro: TIME_SET_TIMEOUT_EN (abort EDIT after
// TIMEOUT_TICKS idle i_ena ticks).
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned BLINK_TICKS   = 60,
    parameter int unsigned TIMEOUT_TICKS = 1200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ena,
    input  logic        i_wr_pulse,
    input  logic        i_val_inc_pulse,
    input  logic        i_val_dec_pulse,
    input  logic        i_sel_inc_pulse,
    input  logic        i_sel_dec_pulse,
    input  logic [23:0] i_time,
    output logic [23:0] o_time,
    output logic        o_load,
    output logic        o_editing,
    output logic [1:0]  o_sel,
    output logic [2:0]  o_blank
);

    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    // Reject parameter values the counters cannot represent.
    if ((BLINK_TICKS == 0) || (TIMEOUT_TICKS == 0) || (TIMEOUT_TICKS >= (1 << TIMEOUT_W))) begin : g_param_err
        $error("time_set_ctrl: BLINK_TICKS/TIMEOUT_TICKS out of range");
    end

    state_e               state_q, state_d;
    logic [23:0]          buf_q, buf_d;
    logic [1:0]           sel_q, sel_d;
    logic                 load_q, load_d;
    logic                 editing_q, editing_d;
    logic [2:0]           blank_q, blank_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
`ifdef TIME_SET_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic [TIMEOUT_W-1:0] to_cnt_inc;
`endif

    logic in_edit;
    logic any_pulse;
    logic wr_app, sel_inc_app, sel_dec_app, val_inc_app, val_dec_app;
    logic edit_app;
    logic [7:0] ss_step, mm_step, hh_step;

    // Resolve which single pulse is applied this cycle in EDIT.
    always_comb begin
        in_edit     = (state_q == ST_EDIT);
        any_pulse   = i_sel_inc_pulse | i_sel_dec_pulse | i_val_inc_pulse | i_val_dec_pulse;
        wr_app      = in_edit & i_wr_pulse;
        sel_inc_app = in_edit & ~i_wr_pulse & i_sel_inc_pulse;
        sel_dec_app = in_edit & ~i_wr_pulse & ~i_sel_inc_pulse & i_sel_dec_pulse;
        val_inc_app = in_edit & ~i_wr_pulse & ~i_sel_inc_pulse & ~i_sel_dec_pulse
                      & i_val_inc_pulse;
        val_dec_app = in_edit & ~i_wr_pulse & ~i_sel_inc_pulse & ~i_sel_dec_pulse
                      & ~i_val_inc_pulse & i_val_dec_pulse;
        edit_app    = sel_inc_app | sel_dec_app | val_inc_app | val_dec_app;
    end

    bcd_field_step u_step_ss (
        .value_i (buf_q[7:0]),
        .max_i   (BCD_MAX_MS),
        .inc_i   (val_inc_app && (sel_q == SEL_SS)),
        .dec_i   (val_dec_app && (sel_q == SEL_SS)),
        .value_o (ss_step)
    );

    bcd_field_step u_step_mm (
        .value_i (buf_q[15:8]),
        .max_i   (BCD_MAX_MS),
        .inc_i   (val_inc_app && (sel_q == SEL_MM)),
        .dec_i   (val_dec_app && (sel_q == SEL_MM)),
        .value_o (mm_step)
    );

    bcd_field_step u_step_hh (
        .value_i (buf_q[23:16]),
        .max_i   (BCD_MAX_HH),
        .inc_i   (val_inc_app && (sel_q == SEL_HH)),
        .dec_i   (val_dec_app && (sel_q == SEL_HH)),
        .value_o (hh_step)
    );

    // Next-state, buffer, counters and registered-output decode.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        sel_d       = sel_q;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
        to_cnt_d    = '0;
        to_cnt_inc  = to_cnt_q + TIMEOUT_W'(1);
`endif

        case (state_q)
            ST_RUN: begin
                if (any_pulse) begin
                    // Entry pulse is consumed; buffer freezes at its current value.
                    state_d = ST_EDIT;
                    sel_d   = SEL_SS;
                end else begin
                    buf_d = i_time;
                end
            end

            ST_EDIT: begin
                blink_cnt_d = blink_cnt_q;
                phase_d     = phase_q;
`ifdef TIME_SET_TIMEOUT_EN
                to_cnt_d    = to_cnt_q;
`endif
                if (wr_app) begin
                    state_d     = ST_COMMIT;
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end else if (edit_app) begin
                    // Applied edits restart blink visible and restart the idle count.
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                    if (sel_inc_app) begin
                        sel_d = (sel_q == SEL_HH) ? SEL_SS : sel_q + 2'd1;
                    end else if (sel_dec_app) begin
                        sel_d = (sel_q == SEL_SS) ? SEL_HH : sel_q - 2'd1;
                    end else begin
                        case (sel_q)
                            SEL_SS:  buf_d[7:0]   = ss_step;
                            SEL_MM:  buf_d[15:8]  = mm_step;
                            SEL_HH:  buf_d[23:16] = hh_step;
                            default: buf_d        = buf_q;
                        endcase
                    end
                end else if (i_ena) begin
                    if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
`ifdef TIME_SET_TIMEOUT_EN
                    if (to_cnt_inc == TIMEOUT_W'(TIMEOUT_TICKS)) begin
                        state_d     = ST_RUN;
                        to_cnt_d    = '0;
                        blink_cnt_d = '0;
                        phase_d     = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_inc;
                    end
`endif
                end
            end

            ST_COMMIT: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        load_d    = (state_d == ST_COMMIT);
        editing_d = (state_d == ST_EDIT);
        blank_d   = (editing_d && phase_d) ? field_onehot(sel_d) : 3'b000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            buf_q       <= '0;
            sel_q       <= SEL_SS;
            load_q      <= 1'b0;
            editing_q   <= 1'b0;
            blank_q     <= 3'b000;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            sel_q       <= sel_d;
            load_q      <= load_d;
            editing_q   <= editing_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`ifdef TIME_SET_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign o_time    = buf_q;
    assign o_load    = load_q;
    assign o_editing = editing_q;
    assign o_sel     = sel_q;
    assign o_blank   = blank_q;

endmodule
